// File: rtl/hps_command_sequencer_pkg.sv
// Shared definitions for the HPS command sequencer: accelerator opcodes,
// sequencer state encoding and instruction word field positions.
package hps_cmd_pkg;

    // Opcodes, identical to the accelerator's instruction decode
    localparam logic [3:0] OP_READ        = 4'b0001;
    localparam logic [3:0] OP_WRITE       = 4'b0010;
    localparam logic [3:0] OP_CONV        = 4'b0101;
    localparam logic [3:0] OP_CONV_TRSP   = 4'b0110;
    localparam logic [3:0] OP_CONV_ROB    = 4'b0111;
    localparam logic [3:0] OP_B2G         = 4'b1000;
    localparam logic [3:0] OP_PHOTO_CONV  = 4'b1110;
    localparam logic [3:0] OP_READ_IMAGE  = 4'b1111;

    // Instruction word fields
    localparam int unsigned OP_LSB   = 0;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned ADDR_LSB = 4;
    localparam int unsigned ADDR_W   = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_PH_HOLD,
        ST_PH_RELEASE,
        ST_RESP
    } seq_state_t;

    // READ_IMAGE instruction word for a given image address
    function automatic logic [31:0] read_image_instr(input logic [15:0] addr);
        logic [31:0] w;
        w = '0;
        w[ADDR_LSB +: ADDR_W] = addr;
        w[OP_LSB +: OP_W]     = OP_READ_IMAGE;
        return w;
    endfunction

endpackage

// File: rtl/hps_command_sequencer_timer.sv
// Loadable down-counter with a zero flag; shared by the ack timeout,
// RAM latency and PHOTO_CONV hold intervals.
module sequencer_timer #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority; counting stops at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hps_command_sequencer.sv
// Host-side initiator for the accelerator command port. Turns host commands
// into timed instruction/activate sequences and returns results on a
// valid/ready response stream.
module hps_command_sequencer
    import hps_cmd_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 2,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [27:0] cmd_arg,
    input  logic [15:0] cmd_count,
    output logic [31:0] instruction,
    output logic [1:0]  activate_signal,
    input  logic        wait_signal,
    input  logic [31:0] data_read,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned TMR_MAX =
        (ACK_TIMEOUT > RAM_LATENCY) ?
            ((ACK_TIMEOUT > HOLD_CYCLES) ? ACK_TIMEOUT : HOLD_CYCLES) :
            ((RAM_LATENCY > HOLD_CYCLES) ? RAM_LATENCY : HOLD_CYCLES);
    localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);

    // Timer is loaded with N-1 so the waiting state lasts exactly N cycles
    localparam logic [TMR_W-1:0] ACK_LOAD  = TMR_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [TMR_W-1:0] LAT_LOAD  = TMR_W'((RAM_LATENCY > 0) ? RAM_LATENCY - 1 : 0);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    seq_state_t  state;
    seq_state_t  state_nxt;

    logic [3:0]  op_q;
    logic [27:0] arg_q;
    logic [15:0] addr_q;
    logic [15:0] remain_q;
    logic [31:0] rsp_data_q;
    logic        rsp_last_q;
    logic        rsp_err_q;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_en;
    logic             tmr_zero;

    logic        is_burst;
    logic        more_words;

    assign is_burst   = (op_q == OP_READ_IMAGE);
    assign more_words = is_burst && (remain_q > 16'd1);

    sequencer_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .en         (tmr_en),
        .zero       (tmr_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_PHOTO_CONV) begin
                        state_nxt = ST_PH_HOLD;
                    end else if (cmd_op == OP_READ_IMAGE) begin
                        state_nxt = ST_RD_ADDR;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            // A busy flag already high at issue counts as the ack
            ST_ISSUE:      state_nxt = wait_signal ? ST_WAIT_DONE : ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (wait_signal) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (tmr_zero) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_WAIT_DONE:  if (!wait_signal) state_nxt = ST_RESP;
            ST_RD_ADDR:    state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:    if (tmr_zero) state_nxt = ST_RESP;
            ST_PH_HOLD:    if (tmr_zero) state_nxt = ST_PH_RELEASE;
            ST_PH_RELEASE: state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = more_words ? ST_RD_ADDR : ST_IDLE;
                end
            end
            default:       state_nxt = ST_IDLE;
        endcase
    end

    // Outputs and timer control decoded from the current state
    always_comb begin
        cmd_ready       = (state == ST_IDLE);
        busy            = (state != ST_IDLE);
        activate_signal = (state == ST_ISSUE) ? 2'b01 : 2'b00;
        rsp_valid       = (state == ST_RESP);
        rsp_data        = rsp_data_q;
        rsp_last        = rsp_last_q;
        rsp_err         = rsp_err_q;
        instruction     = '0;
        tmr_load        = 1'b0;
        tmr_value       = '0;
        tmr_en          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && (cmd_op == OP_PHOTO_CONV)) begin
                    tmr_load  = 1'b1;
                    tmr_value = HOLD_LOAD;
                end
            end
            ST_ISSUE: begin
                instruction = {arg_q, op_q};
                tmr_load    = 1'b1;
                tmr_value   = ACK_LOAD;
            end
            ST_WAIT_ACK: begin
                instruction = {arg_q, op_q};
                tmr_en      = 1'b1;
            end
            ST_WAIT_DONE: instruction = {arg_q, op_q};
            ST_RD_ADDR: begin
                instruction = read_image_instr(addr_q);
                tmr_load    = 1'b1;
                tmr_value   = LAT_LOAD;
            end
            ST_RD_WAIT: begin
                instruction = read_image_instr(addr_q);
                tmr_en      = 1'b1;
            end
            ST_PH_HOLD: begin
                instruction = {arg_q, OP_PHOTO_CONV};
                tmr_en      = 1'b1;
            end
            ST_PH_RELEASE: instruction = '0;
            // Burst keeps the address on the bus so data_read stays stable;
            // PHOTO_CONV stays released so the accelerator is not retriggered
            ST_RESP: begin
                if (is_burst) begin
                    instruction = read_image_instr(addr_q);
                end else if (op_q != OP_PHOTO_CONV) begin
                    instruction = {arg_q, op_q};
                end
            end
            default: instruction = '0;
        endcase
    end

    // Command latch, burst bookkeeping and response capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= '0;
            arg_q      <= '0;
            addr_q     <= '0;
            remain_q   <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        arg_q    <= cmd_arg;
                        addr_q   <= cmd_arg[15:0];
                        remain_q <= (cmd_count == 16'd0) ? 16'd1 : cmd_count;
                    end
                end
                ST_WAIT_ACK: begin
                    if (!wait_signal && tmr_zero) begin
                        rsp_data_q <= '0;
                        rsp_last_q <= 1'b1;
                        rsp_err_q  <= 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!wait_signal) begin
                        rsp_data_q <= data_read;
                        rsp_last_q <= 1'b1;
                        rsp_err_q  <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    if (tmr_zero) begin
                        rsp_data_q <= data_read;
                        rsp_last_q <= (remain_q == 16'd1);
                        rsp_err_q  <= 1'b0;
                    end
                end
                ST_PH_RELEASE: begin
                    rsp_data_q <= '0;
                    rsp_last_q <= 1'b1;
                    rsp_err_q  <= 1'b0;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_err_q <= 1'b0;
                        if (more_words) begin
                            remain_q <= remain_q - 16'd1;
                            addr_q   <= addr_q + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/hps_command_sequencer.md
Name: hps_command_sequencer

Overview:
- Host-side initiator for the coprocessor/IPU top-level command port.
- Drives the instruction/activate_signal pair and observes wait_signal/data_read exactly as the HPS bridge would.
- Converts simple host commands (single op, image readback burst, PHOTO_CONV trigger) into correctly timed instruction sequences and returns results on a valid/ready response stream.
- Sits between the HPS PIO/bridge logic and the accelerator top.

Parameters:
- RAM_LATENCY, 2: cycles from a READ_IMAGE address change to data_read being valid.
- ACK_TIMEOUT, 1024: max cycles to wait for wait_signal to rise after activation.
- HOLD_CYCLES, 4: cycles PHOTO_CONV is held on instruction before being released.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_op  in  4  opcode: READ 0001, WRITE 0010, CONV 0101, CONV_TRSP 0110, CONV_ROB 0111, B2G 1000, PHOTO_CONV 1110, READ_IMAGE 1111
- cmd_arg  in  28  instruction bits [31:4]; for READ_IMAGE, [15:0] is the start address
- cmd_count  in  16  READ_IMAGE word count (0 treated as 1)
- instruction  out  32  to accelerator
- activate_signal  out  2  to accelerator; bit0 = activate
- wait_signal  in  1  from accelerator, busy flag
- data_read  in  32  from accelerator
- rsp_valid  out  1  response word available
- rsp_ready  in  1  host accepts response
- rsp_data  out  32  response word
- rsp_last  out  1  final word of a command
- rsp_err  out  1  ack timeout occurred (valid with rsp_valid)
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; instruction=0, activate_signal=0, rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0, busy=0; all counters 0.
- Reset mid-operation abandons the command. instruction returns to 0 the next cycle, and no response is emitted.
- Opcode constants are identical to the accelerator's.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RD_ADDR, RD_WAIT, PH_HOLD, PH_RELEASE, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch op/arg/count and go to:
  - PH_HOLD if op=PHOTO_CONV;
  - RD_ADDR if op=READ_IMAGE;
  - ISSUE otherwise.
- Ordinary ops:
  - ISSUE: instruction={arg,op}, activate_signal=01 for exactly one cycle. Next state WAIT_ACK, activate returns to 00.
  - WAIT_ACK: instruction held stable. On wait_signal=1, go to WAIT_DONE. If ACK_TIMEOUT cycles elapse, go to RESP with rsp_err=1 and rsp_data=0.
  - WAIT_DONE: on wait_signal=0, capture data_read into rsp_data and go to RESP (rsp_last=1). instruction stays held until RESP is accepted.
- READ_IMAGE burst:
  - RD_ADDR: instruction={12'b0, addr, 4'b1111}, activate=00; load latency counter.
  - RD_WAIT: count RAM_LATENCY cycles, then capture data_read into rsp_data and go to RESP.
  - rsp_last=1 when the remaining count is 1.
  - After acceptance, if words remain, addr increments (16-bit wrap, FFFF->0000) and returns to RD_ADDR; otherwise IDLE.
  - instruction stays READ_IMAGE-encoded during RESP stalls, so data_read stays stable.
- PHOTO_CONV:
  - PH_HOLD: instruction={arg,1110} for HOLD_CYCLES cycles; activate=00.
  - PH_RELEASE: instruction=0 for one cycle, which re-arms the accelerator's edge detect.
  - Then RESP with rsp_data=0, rsp_last=1. The sequencer does not wait for the frame sweep.
- RESP: rsp_valid=1 until rsp_valid&rsp_ready. The transfer completes in that cycle and rsp_valid drops the next cycle unless the next burst word is already captured (minimum one bubble is allowed).
  - rsp_err clears on acceptance.
  - After the last word: instruction=0, IDLE.
- wait_signal already high at ISSUE: treated as ack (go straight to WAIT_DONE on the next cycle).
- cmd_valid while busy: ignored (cmd_ready=0). Commands are never dropped once accepted.

Decomposition:
- Shared package (hps_cmd_pkg): opcode localparams (shared with the accelerator decode), the state encoding, and the instruction field positions (opcode [3:0], image address [19:4]).
- One natural sub-module, sequencer_timer: a loadable down-counter with a zero flag, reused for ACK_TIMEOUT, RAM_LATENCY and HOLD_CYCLES.

Test Plan:
- Single CONV, arg=28'h0000123:
  - Stimulus: bench holds wait_signal low for 3 cycles, high for 10, then low with data_read=32'h00AB00CD.
  - Required: activate_signal=01 for exactly one cycle; instruction=32'h00001235 stable throughout; one response rsp_data=00AB00CD, rsp_last=1, rsp_err=0.
- Timeout: WRITE with wait_signal held 0 and ACK_TIMEOUT=8 -> response with rsp_err=1, rsp_data=0 after 8 WAIT_ACK cycles; returns to IDLE.
- Burst READ_IMAGE, start=16'hFFFE, count=3, model RAM returns data=addr after 2 cycles:
  - Required: responses 0000FFFE, 0000FFFF, 00000000 (address wraps); rsp_last only on the third word.
  - instruction[19:4] sequence is FFFE, FFFF, 0000.
- Backpressure: same burst with rsp_ready low for 5 cycles on word 2 -> rsp_data and instruction stable during the stall; no word lost or duplicated.
- PHOTO_CONV, arg[2:0]=3'b010:
  - Required: instruction=32'h00000 02E for 4 cycles, then 0 for one cycle, then a response with data 0.
  - A second PHOTO_CONV immediately after repeats the identical pattern.
- Reset mid-burst: assert rst_n=0 during RD_WAIT of word 2 -> next cycle instruction=0, rsp_valid=0, cmd_ready=1 after release; the following READ command behaves normally.
